// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: pointer type and gray/binary conversion.
// Latency: pure combinational functions, no state.
// Backpressure: not applicable; callers cast to and from ptr_t and truncate to their own width.
package fifo_pkg;

   // Widest pointer any caller may pass; narrower pointers are zero-extended.
   localparam int PTR_MAX_W = 32;

   typedef logic [PTR_MAX_W-1:0] ptr_t;

   function automatic ptr_t bin2gray(input ptr_t b);
      return b ^ (b >> 1);
   endfunction

   // Zero-extended upper bits stay zero, so the result is exact for any narrower width.
   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
      for (int i = PTR_MAX_W-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Multi-flop synchroniser for a gray-coded pointer entering a new clock domain.
// Latency: STAGES clk edges from d to q.
// Backpressure: none; samples every cycle, synchronous active-high reset clears the chain.
module gray_ptr_sync #(
   parameter int WIDTH  = 6,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] chain [STAGES];

   // Shift the gray pointer through the synchroniser chain.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) begin
            chain[i] <= '0;
         end
      end else begin
         chain[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            chain[i] <= chain[i-1];
         end
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/async_fifo_levels.sv
// Dual-clock FIFO with gray pointer crossing, per-domain fill levels and almost flags.
// Latency: 1 rd_clk read latency; writes visible to the reader SYNC_STAGES+1 rd_clk edges later.
// Backpressure: writes dropped while wr_full, reads ignored while rd_empty; define ASYNC_FIFO_FWFT_EN for a first-word-fall-through read side.
module async_fifo_levels
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH          = 16,
   parameter int ADDR_WIDTH          = 5,
   parameter int SYNC_STAGES         = 2,
   parameter int ALMOST_FULL_THRESH  = (1 << ADDR_WIDTH) - 4,
   parameter int ALMOST_EMPTY_THRESH = 4
) (
   input  logic                  rd_clk,
   input  logic                  wr_clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_full,
   output logic                  wr_almost_full,
   output logic [ADDR_WIDTH:0]   wr_level,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  rd_empty,
   output logic                  rd_almost_empty,
   output logic [ADDR_WIDTH:0]   rd_level
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int PW    = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH:0] AF_T = PW'(ALMOST_FULL_THRESH);
   localparam logic [ADDR_WIDTH:0] AE_T = PW'(ALMOST_EMPTY_THRESH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // ---------------- write domain ----------------
   logic                wr_push;
   logic [ADDR_WIDTH:0] wr_bin, wr_gray, wr_bin_next, wr_gray_next;
   logic [ADDR_WIDTH:0] rd_gray_wsync, wr_level_next;
   logic                wr_full_next;

   assign wr_push       = wr_en & ~wr_full;
   assign wr_bin_next   = wr_bin + {{ADDR_WIDTH{1'b0}}, wr_push};
   assign wr_gray_next  = PW'(bin2gray(ptr_t'(wr_bin_next)));
   assign wr_level_next = wr_bin_next - PW'(gray2bin(ptr_t'(rd_gray_wsync)));
   // Full when the writer is exactly one lap ahead of the (possibly stale) read pointer.
   assign wr_full_next  = (wr_gray_next == {~rd_gray_wsync[ADDR_WIDTH -: 2],
                                            rd_gray_wsync[ADDR_WIDTH-2:0]});

   // Write pointers and write-side status, decoded from the post-write pointer.
   always_ff @(posedge wr_clk) begin
      if (reset) begin
         wr_bin   <= '0;
         wr_gray  <= '0;
         wr_full  <= 1'b0;
         wr_level <= '0;
      end else begin
         wr_bin   <= wr_bin_next;
         wr_gray  <= wr_gray_next;
         wr_full  <= wr_full_next;
         wr_level <= wr_level_next;
      end
   end

   // Storage write; contents are deliberately left uninitialised by reset.
   always_ff @(posedge wr_clk) begin
      if (wr_push && !reset) begin
         mem[wr_bin[ADDR_WIDTH-1:0]] <= wr_data;
      end
   end

   assign wr_almost_full = (wr_level >= AF_T);

   gray_ptr_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_rd2wr_sync (
      .clk   (wr_clk),
      .reset (reset),
      .d     (rd_gray),
      .q     (rd_gray_wsync)
   );

   // ---------------- read domain ----------------
   logic                rd_pop;
   logic [ADDR_WIDTH:0] rd_bin, rd_gray, rd_bin_next, rd_gray_next;
   logic [ADDR_WIDTH:0] wr_gray_rsync, mem_level;
   logic                mem_empty;

`ifdef ASYNC_FIFO_FWFT_EN
   // Prefetch whenever the output register is free or being acknowledged.
   assign rd_pop = ~mem_empty & (~rd_valid | rd_en);
`else
   assign rd_pop = rd_en & ~mem_empty;
`endif

   assign rd_bin_next  = rd_bin + {{ADDR_WIDTH{1'b0}}, rd_pop};
   assign rd_gray_next = PW'(bin2gray(ptr_t'(rd_bin_next)));

   // Read pointers and memory occupancy, decoded from the post-read pointer.
   always_ff @(posedge rd_clk) begin
      if (reset) begin
         rd_bin    <= '0;
         rd_gray   <= '0;
         mem_empty <= 1'b1;
         mem_level <= '0;
      end else begin
         rd_bin    <= rd_bin_next;
         rd_gray   <= rd_gray_next;
         mem_empty <= (rd_gray_next == wr_gray_rsync);
         mem_level <= PW'(gray2bin(ptr_t'(wr_gray_rsync))) - rd_bin_next;
      end
   end

   // Output register: holds its word until the next pop.
   always_ff @(posedge rd_clk) begin
      if (reset) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
`ifdef ASYNC_FIFO_FWFT_EN
         if (rd_pop) begin
            rd_data  <= mem[rd_bin[ADDR_WIDTH-1:0]];
            rd_valid <= 1'b1;
         end else if (rd_en) begin
            rd_valid <= 1'b0;
         end
`else
         rd_valid <= rd_pop;
         if (rd_pop) begin
            rd_data <= mem[rd_bin[ADDR_WIDTH-1:0]];
         end
`endif
      end
   end

`ifdef ASYNC_FIFO_FWFT_EN
   assign rd_empty = ~rd_valid;
   assign rd_level = mem_level + {{ADDR_WIDTH{1'b0}}, rd_valid};
`else
   assign rd_empty = mem_empty;
   assign rd_level = mem_level;
`endif

   assign rd_almost_empty = (rd_level <= AE_T);

   gray_ptr_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_wr2rd_sync (
      .clk   (rd_clk),
      .reset (reset),
      .d     (wr_gray),
      .q     (wr_gray_rsync)
   );

endmodule

// File: doc/async_fifo_levels.md
Name: async_fifo_levels

Overview:
Parametrised dual-clock FIFO for crossing data between independent write and read clock domains.
- Gray-coded pointers crossing through SYNC_STAGES-deep synchroniser chains.
- Registered read data with a 1-cycle read latency.
- Per-domain fill levels and programmable almost-full / almost-empty flags.
- Sits between a producer in wr_clk and a consumer in rd_clk, e.g. sample streams and packet buffers.

Parameters:
DATA_WIDTH, 16, word width in bits.
ADDR_WIDTH, 5, log2 of depth; DEPTH = 2**ADDR_WIDTH; only power-of-two depths are supported.
SYNC_STAGES, 2, flops per pointer synchroniser chain; minimum 2.
ALMOST_FULL_THRESH, DEPTH-4, wr_almost_full asserts when wr_level >= this value.
ALMOST_EMPTY_THRESH, 4, rd_almost_empty asserts when rd_level <= this value.

Ports:
rd_clk  in  1  read-domain clock.
wr_clk  in  1  write-domain clock.
reset  in  1  synchronous, active-high reset, sampled in each domain on its own clock.
wr_en  in  1  write request.
wr_data  in  DATA_WIDTH  write word.
wr_full  out  1  FIFO full as seen from the write domain.
wr_almost_full  out  1  wr_level >= ALMOST_FULL_THRESH.
wr_level  out  ADDR_WIDTH+1  occupancy as seen from the write domain.
rd_en  in  1  read request (pop).
rd_data  out  DATA_WIDTH  registered read word.
rd_valid  out  1  rd_data holds a freshly read word.
rd_empty  out  1  FIFO empty as seen from the read domain.
rd_almost_empty  out  1  rd_level <= ALMOST_EMPTY_THRESH.
rd_level  out  ADDR_WIDTH+1  occupancy as seen from the read domain.

Behaviour:
- Reset: reset, synchronous, active-high; clock rd_clk. The same reset is also sampled synchronously on wr_clk for the write-domain state. Reset must be held for at least SYNC_STAGES+1 cycles of the slower clock.
- Reset values:
  - Binary and gray pointers, and all synchroniser flops, go to 0.
  - rd_data = 0, rd_valid = 0, rd_empty = 1, rd_almost_empty = 1, rd_level = 0.
  - wr_full = 0, wr_almost_full = 0 (unless ALMOST_FULL_THRESH = 0), wr_level = 0.
  - Memory contents are not cleared.
- Pointers: ADDR_WIDTH+1 bits, held both binary and gray, all registered. The MSB is the wrap bit. Only gray values cross domains. Increments wrap modulo 2**(ADDR_WIDTH+1).
- Write: on a wr_clk edge with wr_en=1 and wr_full=0, wr_data is stored at wr_ptr[ADDR_WIDTH-1:0] and wr_ptr increments. A write while full is dropped; pointer and memory are unchanged.
- Full: wr_gray == synced rd_gray with its top two bits inverted. It is decoded from registered values, so it is true in the same cycle the DEPTH-th write lands.
- Read: on an rd_clk edge with rd_en=1 and rd_empty=0, rd_data <= mem[rd_ptr] and rd_ptr increments. rd_valid is 1 on the following cycle only. A read while empty is ignored and rd_valid = 0 next cycle. rd_data holds its value when no read occurs.
- Empty: rd_gray == synced wr_gray.
- Levels, computed modulo 2**(ADDR_WIDTH+1):
  - wr_level = wr_bin - g2b(synced rd_gray).
  - rd_level = g2b(synced wr_gray) - rd_bin.
  - Range is 0..DEPTH inclusive.
- Crossing latency:
  - A write becomes visible to rd_empty / rd_level SYNC_STAGES+1 rd_clk edges after the wr_clk edge.
  - A read frees space for wr_full / wr_level SYNC_STAGES+1 wr_clk edges after the rd_clk edge.
  - Both flags are conservative: never false-not-full, never false-not-empty.
- Simultaneous read and write at equal occupancy: both proceed; there is no bypass path.
- Reset mid-operation: in-flight data is discarded. Flags reach their reset values within one cycle of their domain.

Optional Feature:
ASYNC_FIFO_FWFT_EN. When defined, the read side is first-word-fall-through:
- An internal prefetch loads the output register automatically whenever it is empty and the memory is non-empty.
- rd_valid stays high while rd_data holds an unconsumed word; rd_en acts as acknowledge and only has effect when rd_valid=1.
- rd_empty = ~rd_valid, and rd_level includes the output-register word.
- First-word latency after a write is SYNC_STAGES+2 rd_clk edges.

When undefined, the standard 1-cycle-latency read described above applies.

Decomposition:
- Package fifo_pkg holds the bin2gray and gray2bin functions, parametrised by width through the caller, and the ptr_t typedef helper.
- One sub-module, gray_ptr_sync: a SYNC_STAGES-deep, ADDR_WIDTH+1-wide synchroniser with synchronous reset. It is instantiated twice, once per direction.

Test Plan:
1. wr_clk 100 MHz, rd_clk 37 MHz, DEPTH=32; write 0..31 with rd_en=0 -> wr_full=1 after the 32nd write; a 33rd write (0xBEEF) is dropped; wr_level=32.
2. Continue from test 1, reading 32 words -> rd_data sequence is 0..31 with no 0xBEEF; rd_empty=1 after the last read; further rd_en gives rd_valid=0.
3. Single write of 0x1234 into an empty FIFO with SYNC_STAGES=2 -> rd_empty falls exactly 3 rd_clk edges later; rd_level=1; rd_almost_empty=1.
4. Fill to 28 words -> wr_almost_full=1 at wr_level=28 and 0 at 27; read down to 4 -> rd_almost_empty asserts at rd_level=4.
5. Random 10k-word streaming with both clocks swept, including 2**(ADDR_WIDTH+1) pointer wrap -> output equals input order; no overflow or underflow.
6. Assert reset for 4 cycles of each clock with 20 words stored -> wr_level=0, rd_level=0, rd_empty=1, wr_full=0; the next write and read of 0xA5A5 round-trips correctly.
